regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
// Shares the single register-file write port (wEn/addrD/dataD) between two writeback sources:
// the ALU and the load/store unit. A fixed-priority arbiter has a starvation guard. The output
// stage is registered and drives the register file directly. A 32-bit pending scoreboard flags
// RAW/WAW hazards to decode so issue stalls until in-flight results are committed.
// PARAMETERS
// DATA_W      32  writeback data width
// ADDR_W      5   register address width (2**ADDR_W registers, index 0 hardwired zero)
// STARVE_MAX  3   consecutive lost ALU cycles before ALU is forced to win
// PORTS
// clk         in   1       single clock, all state on posedge
// rst_n       in   1       asynchronous, active-low reset
// issue_valid in   1       decode issues an instr writing issue_rd this cycle
// issue_rd    in   ADDR_W  destination of issued instr; also checked for WAW
// rs1_addr    in   ADDR_W  decode source 1
// rs2_addr    in   ADDR_W  decode source 2
// hazard      out  1       comb: pending[rs1]|pending[rs2]|pending[issue_rd], index 0 masked
// alu_valid   in   1       ALU result available
// alu_rd      in   ADDR_W  ALU destination
// alu_data    in   DATA_W  ALU result
// alu_ready   out  1       comb grant to ALU; transfer = alu_valid&alu_ready
// mem_valid   in   1       load result available
// mem_rd      in   ADDR_W  load destination
// mem_data    in   DATA_W  load result
// mem_ready   out  1       comb grant to MEM; transfer = mem_valid&mem_ready
// rf_wEn      out  1       registered write enable to register file
// rf_addrD    out  ADDR_W  registered write address
// rf_dataD    out  DATA_W  registered write data
// pending     out  2**ADDR_W  scoreboard bits, for debug/bench
// BEHAVIOUR
// - Reset (async, rst_n=0): rf_wEn=0, rf_addrD=0, rf_dataD=0, pending=0, starve_cnt=0. Takes
//   effect immediately, mid-transfer included; in-flight results are dropped.
// - Arbitration per cycle: force_alu = (starve_cnt==STARVE_MAX).
//   mem_ready = !force_alu | !alu_valid; alu_ready = !mem_valid | force_alu.
//   At most one transfer per cycle. Ready never depends on its own valid.
// - starve_cnt: +1 (saturating at STARVE_MAX) when alu_valid & !alu_ready; 0 on ALU transfer or
//   when !alu_valid.
// - Output stage, latency 1: on transfer, next edge loads rf_addrD/rf_dataD from the winner and
//   sets rf_wEn=1, except rd==0, where rf_wEn=0. The handshake still completes and the data is
//   discarded. With no transfer, rf_wEn=0 and addr/data hold.
// - Scoreboard: set pending[issue_rd] on issue_valid & issue_rd!=0. Clear pending[rf_addrD] on
//   the edge where rf_wEn=1, i.e. the commit edge, so hazard covers the in-flight cycle.
//   Set and clear of the same index on the same edge: set wins. pending[0] is constant 0.
// - Register-file write is visible to the comb read on the cycle after commit. hazard drops on
//   that same cycle, so no forwarding is needed.
// - Upstream contract: issue_valid is asserted only when hazard=0. The block does not re-check it,
//   and the bench asserts it.
// - Producers hold valid/rd/data stable until transfer. Values are sampled only at transfer.
// STRUCTURE
// - Shared header regfile_defs.vh: RF_ADDR_W=5, RF_DATA_W=32, RF_ZERO=0, STARVE_MAX default.
// - One sub-module: rf_scoreboard (pending vector with set/clear ports and hazard lookup).
//   Arbiter, starvation counter and output register stay in the top.
// TESTING
// 1 Reset: rst_n=0 mid-transfer (rf_wEn=1) -> rf_wEn=0 and pending=0 with no clock edge.
// 2 Single ALU: issue rd=5; alu_valid rd=5 data=0xDEADBEEF -> alu_ready=1; next cycle rf_wEn=1,
//   addr=5, data=0xDEADBEEF; pending[5] clears after that edge.
// 3 Contention: alu_valid and mem_valid held for 8 cycles -> MEM wins 3, ALU forced on 4th,
//   starve_cnt returns to 0.
// 4 x0 write: mem_valid rd=0 data=0x1234 -> mem_ready=1; rf_wEn stays 0; pending unchanged.
// 5 Hazard: issue rd=7; rs1=7 -> hazard=1 until the cycle after commit of rd 7; rs1=0 -> never.
// 6 Collision: commit rd=9 on the same edge as issue rd=9 -> pending[9] stays 1.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file writeback constants for the arbiter and its scoreboard.
// Pure definitions: no logic, no latency.
// Defaults match a 32 x 32-bit register file with x0 hardwired to zero.
package regfile_wb_arbiter_pkg;

  localparam int RF_ADDR_W      = 5;
  localparam int RF_DATA_W      = 32;
  localparam int RF_ZERO        = 0;
  localparam int STARVE_MAX_DEF = 3;

  // True when an address names the hardwired-zero register.
  function automatic logic is_zero_reg(input logic [RF_ADDR_W-1:0] addr);
    return addr == RF_ADDR_W'(RF_ZERO);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at commit.
// Latency: set/clear visible one edge later; hazard lookup is combinational.
// No backpressure of its own; decode stalls on hazard.
module regfile_wb_arbiter_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [ADDR_W-1:0]    set_addr,
  input  logic                 clr_en,
  input  logic [ADDR_W-1:0]    clr_addr,
  input  logic [ADDR_W-1:0]    rs1,
  input  logic [ADDR_W-1:0]    rs2,
  input  logic [ADDR_W-1:0]    rd,
  output logic                 hazard,
  output logic [2**ADDR_W-1:0] pending
);

  logic [2**ADDR_W-1:0] pending_nxt;

  // Next scoreboard: clear the committing register, then set the issuing one so a
  // same-edge set overrides the clear; x0 never becomes pending.
  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_addr] = 1'b0;
    if (set_en) pending_nxt[set_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  // RAW on either source or WAW on the destination; index 0 masked explicitly.
  always_comb begin
    hazard = (pending[rs1] & (rs1 != '0)) |
             (pending[rs2] & (rs2 != '0)) |
             (pending[rd]  & (rd  != '0));
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writeback, with a hazard scoreboard.
// Latency: one cycle from transfer to rf_wEn/rf_addrD/rf_dataD.
// Backpressure: MEM wins contention unless ALU has lost STARVE_MAX cycles in a row.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_rd,
  input  logic [ADDR_W-1:0]    rs1_addr,
  input  logic [ADDR_W-1:0]    rs2_addr,
  output logic                 hazard,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [ADDR_W-1:0]    mem_rd,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 mem_ready,
  output logic                 rf_wEn,
  output logic [ADDR_W-1:0]    rf_addrD,
  output logic [DATA_W-1:0]    rf_dataD,
  output logic [2**ADDR_W-1:0] pending
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]  starve_cnt;
  logic              force_alu;
  logic              alu_xfer;
  logic              mem_xfer;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;

  // Grants: MEM has priority, except when ALU has starved long enough. Each ready
  // looks only at the other source's valid, so at most one transfer per cycle.
  always_comb begin
    force_alu = (starve_cnt == STARVE_LIM);
    mem_ready = !force_alu | !alu_valid;
    alu_ready = !mem_valid | force_alu;
    alu_xfer  = alu_valid & alu_ready;
    mem_xfer  = mem_valid & mem_ready;
    win_rd    = alu_xfer ? alu_rd   : mem_rd;
    win_data  = alu_xfer ? alu_data : mem_data;
  end

  // Consecutive-loss counter for the ALU; saturates and resets on win or idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (alu_valid && !alu_ready) begin
      if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Registered write port; x0 writes are accepted upstream but dropped here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wEn   <= 1'b0;
      rf_addrD <= '0;
      rf_dataD <= '0;
    end else if ((alu_xfer || mem_xfer) && (win_rd != '0)) begin
      rf_wEn   <= 1'b1;
      rf_addrD <= win_rd;
      rf_dataD <= win_data;
    end else begin
      rf_wEn   <= 1'b0;
    end
  end

  // Clear on the commit edge (rf_wEn high) so hazard still covers the in-flight cycle.
  regfile_wb_arbiter_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue_valid),
    .set_addr (issue_rd),
    .clr_en   (rf_wEn),
    .clr_addr (rf_addrD),
    .rs1      (rs1_addr),
    .rs2      (rs2_addr),
    .rd       (issue_rd),
    .hazard   (hazard),
    .pending  (pending)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter with a behavioural reference model.
// Model tracks: who wins each cycle, the committed write, pending registers and ALU loss streak.
module tb_regfile_wb_arbiter;

  localparam int SMAX = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        hazard;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic        rf_wEn;
  logic [4:0]  rf_addrD;
  logic [31:0] rf_dataD;
  logic [31:0] pending;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_pend [32];
  int          m_loss;
  bit          m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          last_alu_win;
  bit          last_mem_win;

  regfile_wb_arbiter #(
    .DATA_W     (32),
    .ADDR_W     (5),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .hazard      (hazard),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .rf_wEn      (rf_wEn),
    .rf_addrD    (rf_addrD),
    .rf_dataD    (rf_dataD),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  function automatic logic [31:0] model_pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit model_hazard(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return m_pend[a] | m_pend[b] | m_pend[c];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_loss = 0;
    m_wen  = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    alu_valid   = 1'b0;
    mem_valid   = 1'b0;
  endtask

  // One clock cycle: check combinational outputs against the model, advance the
  // model by the rules of the block, then check the registered outputs.
  task automatic cycle();
    bit          alu_win, mem_win;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    #1;
    chk("hazard", hazard, model_hazard(rs1_addr, rs2_addr, issue_rd));
    if (issue_valid) chk("issue_contract", hazard, 1'b0);
    alu_win = alu_valid && (!mem_valid || m_loss >= SMAX);
    mem_win = mem_valid && !alu_win;
    chk("alu_xfer", alu_valid & alu_ready, alu_win);
    chk("mem_xfer", mem_valid & mem_ready, mem_win);
    last_alu_win = alu_win;
    last_mem_win = mem_win;
    if (m_wen) m_pend[m_addr] = 1'b0;
    if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
    wrd  = alu_win ? alu_rd : mem_rd;
    wdat = alu_win ? alu_data : mem_data;
    m_wen = 1'b0;
    if ((alu_win || mem_win) && wrd != 0) begin
      m_wen  = 1'b1;
      m_addr = wrd;
      m_data = wdat;
    end
    if (alu_valid && !alu_win) m_loss = (m_loss + 1 > SMAX) ? SMAX : m_loss + 1;
    else                       m_loss = 0;
    @(posedge clk);
    #1;
    chk("rf_wEn", rf_wEn, m_wen);
    chk("rf_addrD", rf_addrD, m_addr);
    chk("rf_dataD", rf_dataD, m_data);
    chk("pending", pending, model_pend_vec());
    chk("starve_cnt", dut.starve_cnt, m_loss);
  endtask

  initial begin
    logic [7:0] pat;
    model_reset();
    // Reset state
    #1;
    chk("reset_wEn", rf_wEn, 1'b0);
    chk("reset_addr", rf_addrD, 5'd0);
    chk("reset_data", rf_dataD, 32'd0);
    chk("reset_pending", pending, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: async reset in the middle of a commit
    issue_valid = 1'b1; issue_rd = 5'd3;
    cycle();
    issue_valid = 1'b0; issue_rd = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA5A5_0003;
    cycle();
    idle();
    chk("pre_reset_wEn", rf_wEn, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midreset_wEn", rf_wEn, 1'b0);
    chk("midreset_pending", pending, 32'd0);
    chk("midreset_data", rf_dataD, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 2: single ALU writeback
    issue_valid = 1'b1; issue_rd = 5'd5;
    cycle();
    issue_valid = 1'b0; issue_rd = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    #1;
    chk("single_alu_ready", alu_ready, 1'b1);
    cycle();
    idle();
    chk("single_wEn", rf_wEn, 1'b1);
    chk("single_addr", rf_addrD, 5'd5);
    chk("single_data", rf_dataD, 32'hDEAD_BEEF);
    chk("single_pend_inflight", pending[5], 1'b1);
    cycle();
    chk("single_pend_cleared", pending[5], 1'b0);

    // 3: contention, both sources valid for 8 cycles
    pat = 8'b1000_1000;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h1000_0000;
    mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 32'h2000_0000;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("contend_alu_win", last_alu_win, pat[i]);
      if (i == 3) chk("contend_starve_zero", dut.starve_cnt, 0);
      if (last_alu_win) begin alu_rd = alu_rd + 5'd1; alu_data = alu_data + 32'd1; end
      if (last_mem_win) begin mem_rd = mem_rd + 5'd1; mem_data = mem_data + 32'd1; end
    end
    idle();
    cycle();

    // 4: write to x0 is accepted but discarded
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h0000_1234;
    #1;
    chk("x0_mem_ready", mem_ready, 1'b1);
    cycle();
    idle();
    chk("x0_wEn", rf_wEn, 1'b0);
    cycle();

    // 5: RAW hazard on rd 7 lasts until the cycle after commit; x0 never hazards
    issue_valid = 1'b1; issue_rd = 5'd7;
    cycle();
    issue_valid = 1'b0; issue_rd = 5'd0; rs1_addr = 5'd7;
    #1;
    chk("haz_set", hazard, 1'b1);
    cycle();
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h7777_0007;
    cycle();
    idle();
    chk("haz_commit_cycle", hazard, 1'b1);
    cycle();
    chk("haz_after_commit", hazard, 1'b0);
    rs1_addr = 5'd0; issue_valid = 1'b1; issue_rd = 5'd0;
    cycle();
    issue_valid = 1'b0;
    chk("haz_x0", hazard, 1'b0);
    chk("pend_x0", pending[0], 1'b0);

    // 6: issue and commit of rd 9 on the same edge; the set wins
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9999_0009;
    cycle();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    #1;
    chk("coll_commit_wEn", rf_wEn, 1'b1);
    chk("coll_commit_addr", rf_addrD, 5'd9);
    cycle();
    issue_valid = 1'b0; issue_rd = 5'd0;
    chk("coll_pend9", pending[9], 1'b1);
    cycle();

    // Randomized traffic with producers holding until transfer
    idle();
    last_alu_win = 1'b0;
    last_mem_win = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (!alu_valid || last_alu_win) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_rd    = 5'($urandom);
        alu_data  = $urandom;
      end
      if (!mem_valid || last_mem_win) begin
        mem_valid = ($urandom_range(0, 3) != 0);
        mem_rd    = 5'($urandom);
        mem_data  = $urandom;
      end
      rs1_addr = 5'($urandom);
      rs2_addr = 5'($urandom);
      issue_rd = 5'($urandom);
      issue_valid = ($urandom_range(0, 1) == 1) && !model_hazard(rs1_addr, rs2_addr, issue_rd);
      cycle();
    end
    idle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
